// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared widths, NOP encoding, FSM states and scoreboard entry type
package hazard_stall_ctrl_pkg;
    localparam int REG_W = 3;
    localparam logic [15:0] NOP = 16'h0800;
    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_t;
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: 3-entry (EX, MEM, WB) in-flight destination shift register with two compare ports
//  clk, rst      clock, sync active-high reset (clears all valids)
//  hold          freeze the shift register this cycle
//  new_entry     entry shifted into EX when not holding
//  cmp_a, cmp_b  register numbers compared against the valid entries
//  hit_a, hit_b  a compared valid entry holds that register
module hazard_scoreboard
    import hazard_stall_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  sb_entry_t        new_entry,
    input  logic [REG_W-1:0] cmp_a,
    input  logic [REG_W-1:0] cmp_b,
    output logic             hit_a,
    output logic             hit_b
);
    sb_entry_t ex, mem, wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else if (!hold) begin
            wb  <= mem;
            mem <= ex;
            ex  <= new_entry;
        end
    end

    function automatic logic match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.v && (e.dst == r);
    endfunction

    // With write-before-read regfile the WB producer is already visible to ID.
    always_comb begin
        hit_a = match(ex, cmp_a) | match(mem, cmp_a) | (!WB_BYPASS & match(wb, cmp_a));
        hit_b = match(ex, cmp_b) | match(mem, cmp_b) | (!WB_BYPASS & match(wb, cmp_b));
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/enable source for the 5-stage pipeline (RAW, branch fetch hold, memory freeze)
//  clk, rst                       clock, sync active-high reset
//  id_rs, id_rt, id_reading_*     ID source operands and whether they are read
//  id_reg_write, id_dst           ID destination write and register
//  id_br_or_jmp                   ID instruction is a branch or jump
//  imem_stall, dmem_stall         instruction / data memory not ready
//  stall_idex                     bubble into ID/EX
//  if_id_en, id_ex_en             PC+IF/ID and ID/EX advance
//  ex_mem_en, mem_wb_en           EX/MEM and MEM/WB advance
//  fetch_squash                   IF/ID loads NOP instead of the fetched word
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int BR_PENALTY = 2,
    parameter bit WB_BYPASS  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_reading_rs,
    input  logic             id_reading_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_br_or_jmp,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             stall_idex,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             fetch_squash
);
    state_t    state;
    logic [2:0] br_cnt;
    logic      hit_rs, hit_rt, raw, accept;
    sb_entry_t new_entry;

    assign raw       = (id_reading_rs & hit_rs) | (id_reading_rt & hit_rt);
    assign accept    = !dmem_stall && !raw;
    assign new_entry = {accept & id_reg_write, id_dst};

    hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .hold      (dmem_stall),
        .new_entry (new_entry),
        .cmp_a     (id_rs),
        .cmp_b     (id_rt),
        .hit_a     (hit_rs),
        .hit_b     (hit_rt)
    );

    // Priority: rst > dmem_stall freeze > raw bubble > fetch squash > normal.
    always_comb begin
        stall_idex   = rst | (!dmem_stall & raw);
        if_id_en     = rst | accept;
        id_ex_en     = rst | !dmem_stall;
        ex_mem_en    = rst | !dmem_stall;
        mem_wb_en    = rst | !dmem_stall;
        fetch_squash = rst | (accept & (imem_stall | (state == BR_WAIT)));
    end

    // br_cnt counts the remaining squash cycles; the window only advances on non-frozen cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            br_cnt <= '0;
        end else if (!dmem_stall) begin
            if (state == BR_WAIT) begin
                br_cnt <= br_cnt - 3'd1;
                if (br_cnt == 3'd1) state <= RUN;
            end else if (accept && id_br_or_jmp) begin
                state  <= BR_WAIT;
                br_cnt <= 3'(BR_PENALTY);
            end
        end
    end
endmodule
